// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//
// Parametrised ID/EX pipeline register for the MIPS pipeline. It moves the
// WB/MEM/EX control bundles, PC+4, the A/B operands, the immediate, the rs/rt/rd
// fields and the jump target from ID to EX with one cycle of latency.
//
// Flow control uses a valid/ready handshake:
//   - in_ready is high when the stage is empty or EX is draining it this cycle,
//     so the stage can stream one instruction per cycle.
//   - flush squashes the held instruction and the incoming one.
//   - While the stage is empty, WB_out and MEM_out read as zero. A bubble
//     therefore never writes the register file or memory.
//
// Register/ALU control is decoded from the registered EX bundle as plain slices:
//   EX[MSB] = RegDst, EX[ALUOP_W:1] = ALUop, EX[0] = ALUSrc.
//
// bubble_cnt counts the edges where EX is ready and the stage will not present
// a valid instruction in the next cycle. The count saturates at all-ones and is
// cleared only by reset.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   ID-side handshake
//   ex_ready/out_valid  EX-side handshake
//   flush               squash stage contents and the incoming instruction
//   *_in / *_out        pipeline fields (WB, MEM, nextAddress, A, B, imm,
//                       Ins25/20/15, tar)
//   EX_in               EX control bundle (no direct output; decoded instead)
//   RegDst/ALUop/ALUSrc decoded from the registered EX bundle
//   bubble_cnt          saturating count of bubbles issued to EX
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TAR_W   = 26,
    parameter int WB_W    = 2,
    parameter int MEM_W   = 4,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 ex_ready,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic [WB_W-1:0]      WB_in,
    output logic [WB_W-1:0]      WB_out,
    input  logic [MEM_W-1:0]     MEM_in,
    output logic [MEM_W-1:0]     MEM_out,
    input  logic [ALUOP_W+1:0]   EX_in,
    input  logic [DATA_W-1:0]    nextAddress_in,
    output logic [DATA_W-1:0]    nextAddress_out,
    input  logic [DATA_W-1:0]    A_in,
    output logic [DATA_W-1:0]    A_out,
    input  logic [DATA_W-1:0]    B_in,
    output logic [DATA_W-1:0]    B_out,
    input  logic [DATA_W-1:0]    imm_in,
    output logic [DATA_W-1:0]    imm_out,
    input  logic [REG_W-1:0]     Ins25_in,
    output logic [REG_W-1:0]     Ins25_out,
    input  logic [REG_W-1:0]     Ins20_in,
    output logic [REG_W-1:0]     Ins20_out,
    input  logic [REG_W-1:0]     Ins15_in,
    output logic [REG_W-1:0]     Ins15_out,
    input  logic [TAR_W-1:0]     tar_in,
    output logic [TAR_W-1:0]     tar_out,
    output logic                 RegDst,
    output logic [ALUOP_W-1:0]   ALUop,
    output logic                 ALUSrc,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [CNT_W-1:0] W_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] W_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Pipeline state
    logic                 r_valid;
    logic [WB_W-1:0]      r_wb;
    logic [MEM_W-1:0]     r_mem;
    logic [ALUOP_W+1:0]   r_ex;
    logic [DATA_W-1:0]    r_next_addr;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [DATA_W-1:0]    r_imm;
    logic [REG_W-1:0]     r_ins25;
    logic [REG_W-1:0]     r_ins20;
    logic [REG_W-1:0]     r_ins15;
    logic [TAR_W-1:0]     r_tar;
    logic [CNT_W-1:0]     r_bubble_cnt;

    // Handshake decisions for the coming edge
    logic                 w_in_ready;
    logic                 w_load;
    logic                 w_next_valid;
    logic                 w_bubble;

    // Decide load, next-cycle validity and bubble issue from the handshake inputs
    always_comb begin
        w_in_ready   = (!r_valid) || ex_ready;
        w_load       = in_valid && w_in_ready && !flush;
        w_next_valid = 1'b0;
        if (flush) begin
            w_next_valid = 1'b0;
        end else if (w_load) begin
            w_next_valid = 1'b1;
        end else if (r_valid && !ex_ready) begin
            w_next_valid = 1'b1;   // stall keeps the held instruction
        end else begin
            w_next_valid = 1'b0;
        end
        // A bubble is issued when EX takes a cycle and nothing valid follows
        w_bubble = ex_ready && !w_next_valid;
    end

    // Valid flag and control bundles; flush clears the side-effecting WB/MEM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_wb    <= {WB_W{1'b0}};
            r_mem   <= {MEM_W{1'b0}};
            r_ex    <= {(ALUOP_W+2){1'b0}};
        end else if (flush) begin
            r_valid <= 1'b0;
            r_wb    <= {WB_W{1'b0}};
            r_mem   <= {MEM_W{1'b0}};
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_wb    <= WB_in;
            r_mem   <= MEM_in;
            r_ex    <= EX_in;
        end else if (r_valid && ex_ready) begin
            r_valid <= 1'b0;       // drain: the data fields keep their old values
        end else begin
            r_valid <= r_valid;
        end
    end

    // Data fields; captured only on load and held otherwise, including on flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_next_addr <= {DATA_W{1'b0}};
            r_a         <= {DATA_W{1'b0}};
            r_b         <= {DATA_W{1'b0}};
            r_imm       <= {DATA_W{1'b0}};
            r_ins25     <= {REG_W{1'b0}};
            r_ins20     <= {REG_W{1'b0}};
            r_ins15     <= {REG_W{1'b0}};
            r_tar       <= {TAR_W{1'b0}};
        end else if (w_load) begin
            r_next_addr <= nextAddress_in;
            r_a         <= A_in;
            r_b         <= B_in;
            r_imm       <= imm_in;
            r_ins25     <= Ins25_in;
            r_ins20     <= Ins20_in;
            r_ins15     <= Ins15_in;
            r_tar       <= tar_in;
        end else begin
            r_a         <= r_a;
        end
    end

    // Saturating bubble counter, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= {CNT_W{1'b0}};
        end else if (w_bubble && (r_bubble_cnt != W_CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + W_CNT_ONE;
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    // Output mapping; WB/MEM are gated so an empty stage looks like a NOP
    always_comb begin
        in_ready        = w_in_ready;
        out_valid       = r_valid;
        if (r_valid) begin
            WB_out  = r_wb;
            MEM_out = r_mem;
        end else begin
            WB_out  = {WB_W{1'b0}};
            MEM_out = {MEM_W{1'b0}};
        end
        nextAddress_out = r_next_addr;
        A_out           = r_a;
        B_out           = r_b;
        imm_out         = r_imm;
        Ins25_out       = r_ins25;
        Ins20_out       = r_ins20;
        Ins15_out       = r_ins15;
        tar_out         = r_tar;
        RegDst          = r_ex[ALUOP_W+1];
        ALUop           = r_ex[ALUOP_W:1];
        ALUSrc          = r_ex[0];
        bubble_cnt      = r_bubble_cnt;
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//
// Directed scenarios followed by randomized traffic. Every check compares the
// DUT against a behavioural model of one pipeline slot held by the bench.
// The DUT counter is narrowed to CNT_W=3 so that saturation is reachable.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int TAR_W   = 26;
    localparam int WB_W    = 2;
    localparam int MEM_W   = 4;
    localparam int ALUOP_W = 2;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid, in_ready, ex_ready, flush, out_valid;
    logic [WB_W-1:0]      WB_in, WB_out;
    logic [MEM_W-1:0]     MEM_in, MEM_out;
    logic [ALUOP_W+1:0]   EX_in;
    logic [DATA_W-1:0]    nextAddress_in, nextAddress_out;
    logic [DATA_W-1:0]    A_in, A_out, B_in, B_out, imm_in, imm_out;
    logic [REG_W-1:0]     Ins25_in, Ins25_out, Ins20_in, Ins20_out, Ins15_in, Ins15_out;
    logic [TAR_W-1:0]     tar_in, tar_out;
    logic                 RegDst, ALUSrc;
    logic [ALUOP_W-1:0]   ALUop;
    logic [CNT_W-1:0]     bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a single slot plus a bubble tally
    bit                   m_valid;
    logic [WB_W-1:0]      m_wb;
    logic [MEM_W-1:0]     m_mem;
    logic [ALUOP_W+1:0]   m_ex;
    logic [DATA_W-1:0]    m_next, m_a, m_b, m_imm;
    logic [REG_W-1:0]     m_i25, m_i20, m_i15;
    logic [TAR_W-1:0]     m_tar;
    int                   m_cnt;

    id_ex_pipe_reg #(
        .DATA_W(DATA_W), .REG_W(REG_W), .TAR_W(TAR_W), .WB_W(WB_W),
        .MEM_W(MEM_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ex_ready(ex_ready), .flush(flush), .out_valid(out_valid),
        .WB_in(WB_in), .WB_out(WB_out),
        .MEM_in(MEM_in), .MEM_out(MEM_out),
        .EX_in(EX_in),
        .nextAddress_in(nextAddress_in), .nextAddress_out(nextAddress_out),
        .A_in(A_in), .A_out(A_out), .B_in(B_in), .B_out(B_out),
        .imm_in(imm_in), .imm_out(imm_out),
        .Ins25_in(Ins25_in), .Ins25_out(Ins25_out),
        .Ins20_in(Ins20_in), .Ins20_out(Ins20_out),
        .Ins15_in(Ins15_in), .Ins15_out(Ins15_out),
        .tar_in(tar_in), .tar_out(tar_out),
        .RegDst(RegDst), .ALUop(ALUop), .ALUSrc(ALUSrc),
        .bubble_cnt(bubble_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_wb = '0; m_mem = '0; m_ex = '0; m_next = '0; m_a = '0; m_b = '0;
        m_imm = '0; m_i25 = '0; m_i20 = '0; m_i15 = '0; m_tar = '0;
        m_cnt = 0;
    endtask

    // One clock edge of the slot, from the inputs currently driven
    task automatic model_edge();
        bit accept;
        accept = in_valid && (!m_valid || ex_ready) && !flush;
        if (flush) begin
            m_valid = 1'b0;
            m_wb    = '0;
            m_mem   = '0;
        end else if (accept) begin
            m_valid = 1'b1;
            m_wb = WB_in; m_mem = MEM_in; m_ex = EX_in; m_next = nextAddress_in;
            m_a = A_in; m_b = B_in; m_imm = imm_in;
            m_i25 = Ins25_in; m_i20 = Ins20_in; m_i15 = Ins15_in; m_tar = tar_in;
        end else if (ex_ready) begin
            m_valid = 1'b0;
        end
        if (ex_ready && !m_valid) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    endtask

    task automatic check_all();
        int e;
        e = int'(m_ex);
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        check_eq("WB_out",    64'(WB_out),    m_valid ? 64'(m_wb)  : 64'd0);
        check_eq("MEM_out",   64'(MEM_out),   m_valid ? 64'(m_mem) : 64'd0);
        check_eq("nextAddr",  64'(nextAddress_out), 64'(m_next));
        check_eq("A_out",     64'(A_out),     64'(m_a));
        check_eq("B_out",     64'(B_out),     64'(m_b));
        check_eq("imm_out",   64'(imm_out),   64'(m_imm));
        check_eq("Ins25",     64'(Ins25_out), 64'(m_i25));
        check_eq("Ins20",     64'(Ins20_out), 64'(m_i20));
        check_eq("Ins15",     64'(Ins15_out), 64'(m_i15));
        check_eq("tar_out",   64'(tar_out),   64'(m_tar));
        check_eq("RegDst",    64'(RegDst),    64'((e >> (ALUOP_W + 1)) & 1));
        check_eq("ALUop",     64'(ALUop),     64'((e >> 1) % (1 << ALUOP_W)));
        check_eq("ALUSrc",    64'(ALUSrc),    64'(e & 1));
        check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
    endtask

    // Drive handshake and A; every other field gets a random value
    task automatic drive(input bit iv, input bit er, input bit fl, input logic [DATA_W-1:0] a);
        in_valid = iv; ex_ready = er; flush = fl; A_in = a;
        WB_in = WB_W'($urandom); MEM_in = MEM_W'($urandom); EX_in = (ALUOP_W+2)'($urandom);
        nextAddress_in = $urandom; B_in = $urandom; imm_in = $urandom;
        Ins25_in = REG_W'($urandom); Ins20_in = REG_W'($urandom); Ins15_in = REG_W'($urandom);
        tar_in = TAR_W'($urandom);
    endtask

    // Check in_ready before the edge, take the edge, then check everything.
    // Called at posedge+1 and returns at posedge+1.
    task automatic step();
        #1;
        check_eq("in_ready", 64'(in_ready), 64'(!m_valid || ex_ready));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset_pulse();
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_WB",    64'(WB_out),    64'd0);
        check_eq("rst_MEM",   64'(MEM_out),   64'd0);
        check_eq("rst_A",     64'(A_out),     64'd0);
        check_eq("rst_cnt",   64'(bubble_cnt), 64'd0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [DATA_W-1:0] vals [4];
        int cnt_before;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();

        // Streaming at one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, vals[i]);
            step();
            check_eq("stream_A", 64'(A_out), 64'(vals[i]));
            check_eq("stream_valid", 64'(out_valid), 64'd1);
            check_eq("stream_cnt", 64'(bubble_cnt), 64'd0);
        end

        // Stall with 0x22 held while 0x33 waits
        drive(1'b1, 1'b1, 1'b0, 32'h22);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h33);
            step();
            check_eq("stall_ready", 64'(in_ready), 64'd0);
            check_eq("stall_A", 64'(A_out), 64'h22);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h33);
        #1;
        check_eq("unstall_ready", 64'(in_ready), 64'd1);
        #1;
        step();
        check_eq("unstall_A", 64'(A_out), 64'h33);

        // Flush drops the held and the incoming instruction
        drive(1'b1, 1'b1, 1'b0, 32'h66);
        WB_in = 2'b11; MEM_in = 4'hF;
        step();
        cnt_before = int'(bubble_cnt);
        drive(1'b1, 1'b1, 1'b1, 32'h55);
        step();
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        check_eq("flush_WB", 64'(WB_out), 64'd0);
        check_eq("flush_MEM", 64'(MEM_out), 64'd0);
        check_eq("flush_A_held", 64'(A_out), 64'h66);
        check_eq("flush_cnt", 64'(bubble_cnt), 64'(cnt_before + 1));

        // Decode of EX bundle 4'b1101
        drive(1'b1, 1'b1, 1'b0, 32'h77);
        EX_in = 4'b1101;
        step();
        check_eq("dec_RegDst", 64'(RegDst), 64'd1);
        check_eq("dec_ALUop", 64'(ALUop), 64'd2);
        check_eq("dec_ALUSrc", 64'(ALUSrc), 64'd1);

        // Reset with the stage full and stalled
        drive(1'b1, 1'b0, 1'b0, 32'h88);
        step();
        async_reset_pulse();

        // Saturation: ten bubbles into a 3-bit counter
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            step();
        end
        check_eq("sat_cnt", 64'(bubble_cnt), 64'd7);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0), $urandom);
            step();
            if ((i % 97) == 50) async_reset_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register for the MIPS pipeline. Replaces the fixed-width ID/EX latch.
- Carries the WB, MEM and EX control bundles, the next PC, the A/B operands, the immediate, the rs/rt/rd fields and the jump target from ID to EX.
- New over the fixed latch: valid/ready handshake with backpressure from EX, synchronous flush for branch/jump squash, and a saturating bubble counter.
- Decodes RegDst, ALUop and ALUSrc from the EX bundle.

Parameters:
- DATA_W, 32, width of nextAddress, A, B and imm
- REG_W, 5, width of each register-address field
- TAR_W, 26, width of the jump target
- WB_W, 2, width of the WB control bundle
- MEM_W, 4, width of the MEM control bundle
- ALUOP_W, 2, width of ALUop; the EX bundle is ALUOP_W+2 bits
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  ID presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- ex_ready  in  1  EX consumes the stage contents this cycle
- flush  in  1  squash the stage contents and the incoming instruction
- out_valid  out  1  stage holds a valid instruction
- WB_in / WB_out  in/out  WB_W  WB control bundle
- MEM_in / MEM_out  in/out  MEM_W  MEM control bundle
- EX_in  in  ALUOP_W+2  EX control bundle: [MSB]=RegDst, [ALUOP_W:1]=ALUop, [0]=ALUSrc
- nextAddress_in / nextAddress_out  in/out  DATA_W  PC+4
- A_in / A_out, B_in / B_out  in/out  DATA_W  register operands
- imm_in / imm_out  in/out  DATA_W  sign-extended immediate
- Ins25_in/out, Ins20_in/out, Ins15_in/out  in/out  REG_W  rs, rt, rd fields
- tar_in / tar_out  in/out  TAR_W  jump target
- RegDst  out  1  decoded from the registered EX bundle
- ALUop  out  ALUOP_W  decoded from the registered EX bundle
- ALUSrc  out  1  decoded from the registered EX bundle
- bubble_cnt  out  CNT_W  count of bubbles issued to EX

Behaviour:
- Reset (asynchronous, active-high): out_valid=0; every data and control output = 0; bubble_cnt=0. Decoded outputs are therefore 0.
- in_ready = !out_valid || ex_ready. This is combinational, with no dependence on in_valid.
- Load condition: load = in_valid && in_ready && !flush.
  - On load: all fields are captured at the rising edge and out_valid<=1.
  - Latency: one cycle from ID to EX.
- Drain: out_valid && ex_ready && !load gives out_valid<=0. Data fields hold their old value.
  - While out_valid=0, WB_out and MEM_out are forced to 0 (combinational gating), so a bubble never writes the register file or memory.
- Stall: out_valid && !ex_ready && !flush gives out_valid and all fields held unchanged.
- flush has priority over every other condition:
  - out_valid<=0 and WB/MEM registers<=0 next edge.
  - The incoming instruction is discarded even if in_valid=1.
  - in_ready still follows its formula.
- Simultaneous drain and load: the new instruction replaces the old one in the same edge, so back-to-back throughput is 1 per cycle.
- Bubble counter:
  - Increments by 1 on each edge where ex_ready=1 and the stage does not present a valid instruction next cycle (drain without load, or flush).
  - Saturates at all-ones, with no wrap.
  - Cleared only by reset.
- Asserting reset mid-stall or mid-flush clears immediately. The first load is possible on the first edge after reset deasserts.
- Decoded outputs are pure slices of the registered EX bundle; they add no extra latency.

Test Plan:
1. Reset: assert reset asynchronously between edges with the stage full -> out_valid, WB_out, MEM_out, A_out and bubble_cnt go to 0 immediately, before any clock edge.
2. Streaming: in_valid=1 and ex_ready=1 for 4 cycles with A_in=0x11,0x22,0x33,0x44 -> A_out shows each value one cycle later; out_valid=1 throughout; bubble_cnt stays 0.
3. Stall: stage holds A=0x22 and ex_ready=0 for 3 cycles while in_valid=1 with A_in=0x33 -> in_ready=0; A_out=0x22 held. When ex_ready=1, in_ready rises and 0x33 loads on the next edge.
4. Flush: stage holds WB_in=2'b11 and MEM_in=4'hF; pulse flush with in_valid=1 and ex_ready=1 -> next cycle out_valid=0, WB_out=0, MEM_out=0, incoming instruction dropped, bubble_cnt+1.
5. Decode: EX_in=4'b1101 with ALUOP_W=2 loaded -> RegDst=1, ALUop=2'b10, ALUSrc=1.
6. Saturation: CNT_W=3 with 10 bubbles (in_valid=0, ex_ready=1) -> bubble_cnt stops at 7.
